// File: rtl/imba_screen_sequencer.sv
// IMBA mode overlay sequencer: welcome splash, running display and clap-toggled menu.
// All timing is counted in VGA frames (frame_tick), never in clock cycles.
// Optional build macro: IMBA_WELCOME_BLINK_EN blinks the welcome text during the splash.
module imba_screen_sequencer #(
  parameter int unsigned WELCOME_FRAMES = 120,
  parameter int unsigned CLAP_HOLDOFF   = 30,
  parameter int unsigned BLINK_HALF     = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic mode_enter,
  input  logic mode_exit,
  input  logic clap,
  output logic welcome_en,
  output logic menu_en,
  output logic active,
  output logic welcome_done
);

  // Out-of-range parameters would silently truncate into the 8-bit counters.
  if (WELCOME_FRAMES < 1 || WELCOME_FRAMES > 255) begin : g_bad_welcome_frames
    $error("WELCOME_FRAMES must be 1..255");
  end
  if (CLAP_HOLDOFF > 255) begin : g_bad_clap_holdoff
    $error("CLAP_HOLDOFF must be 0..255");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_bad_blink_half
    $error("BLINK_HALF must be 1..255");
  end

  localparam logic [7:0] FrameLast = 8'(WELCOME_FRAMES - 1);
  localparam logic [7:0] HoldLoad  = 8'(CLAP_HOLDOFF);

  typedef enum logic [1:0] {StIdle, StWelcome, StRun, StMenu} state_e;

  state_e     state_q, state_d;
  logic [7:0] frame_q, frame_d;
  logic [7:0] holdoff_q, holdoff_d;
  logic       done_d;
  logic       welcome_d, menu_d, active_d;
  logic       clap_ok;

`ifdef IMBA_WELCOME_BLINK_EN
  logic [7:0] blink_q, blink_d;
  logic       phase_q, phase_d;
  localparam logic [7:0] BlinkLast = 8'(BLINK_HALF - 1);
`endif

  assign clap_ok = clap && (holdoff_q == 8'd0);

  // State and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= 8'd0;
      holdoff_q <= 8'd0;
`ifdef IMBA_WELCOME_BLINK_EN
      blink_q   <= 8'd0;
      phase_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      holdoff_q <= holdoff_d;
`ifdef IMBA_WELCOME_BLINK_EN
      blink_q   <= blink_d;
      phase_q   <= phase_d;
`endif
    end
  end

  // Next state and counter updates; exit beats enter beats clap.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    holdoff_d = holdoff_q;
    done_d    = 1'b0;
`ifdef IMBA_WELCOME_BLINK_EN
    blink_d   = blink_q;
    phase_d   = phase_q;
`endif
    // Saturating hold-off countdown; a clap load below overrides it.
    if (frame_tick && (holdoff_q != 8'd0)) begin
      holdoff_d = holdoff_q - 8'd1;
    end
    if (mode_exit) begin
      state_d   = StIdle;
      holdoff_d = 8'd0;
    end else if (mode_enter) begin
      state_d = StWelcome;
      frame_d = 8'd0;
`ifdef IMBA_WELCOME_BLINK_EN
      blink_d = 8'd0;
      phase_d = 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StWelcome: begin
          if (clap_ok) begin
            state_d   = StRun;
            done_d    = 1'b1;
            holdoff_d = HoldLoad;
          end else if (frame_tick) begin
            if (frame_q == FrameLast) begin
              state_d = StRun;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_q + 8'd1;
            end
`ifdef IMBA_WELCOME_BLINK_EN
            if (blink_q == BlinkLast) begin
              blink_d = 8'd0;
              phase_d = ~phase_q;
            end else begin
              blink_d = blink_q + 8'd1;
            end
`endif
          end
        end
        StRun: begin
          if (clap_ok) begin
            state_d   = StMenu;
            holdoff_d = HoldLoad;
          end
        end
        StMenu: begin
          if (clap_ok) begin
            state_d   = StRun;
            holdoff_d = HoldLoad;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode from the next state so the enables change on the sampling edge.
  always_comb begin
`ifdef IMBA_WELCOME_BLINK_EN
    welcome_d = (state_d == StWelcome) && phase_d;
`else
    welcome_d = (state_d == StWelcome);
`endif
    menu_d   = (state_d == StMenu);
    active_d = (state_d != StIdle);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      welcome_en   <= 1'b0;
      menu_en      <= 1'b0;
      active       <= 1'b0;
      welcome_done <= 1'b0;
    end else begin
      welcome_en   <= welcome_d;
      menu_en      <= menu_d;
      active       <= active_d;
      welcome_done <= done_d;
    end
  end

endmodule
